// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with next-PC selection
// (sequential / CBZ / B / BL / RET) and a circular return-address stack.
module pc_sequencer #(
  parameter int                ADDR_W    = 64,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                IMM_SHIFT = 2
) (
  input  logic                           CLK,
  input  logic                           Reset_L,
  input  logic                           Stall,
  input  logic                           Branch,
  input  logic                           ALUZero,
  input  logic                           Uncondbranch,
  input  logic                           Link,
  input  logic                           Ret,
  input  logic [ADDR_W-1:0]              SignExtImm64,
  output logic [ADDR_W-1:0]              CurrentPC,
  output logic [ADDR_W-1:0]              NextPC,
  output logic [$clog2(RAS_DEPTH+1)-1:0] RasCount,
  output logic                           RasOverflow,
  output logic                           RasUnderflow
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(1) << IMM_SHIFT;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]     r_top;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf, r_unf;

  logic [ADDR_W-1:0] w_seq, w_tgt, w_next;
  logic [PW-1:0]     w_top_inc, w_top_dec;
  logic              w_push, w_pop, w_full, w_empty;

  // Next-PC selection; Ret outranks B/BL, which outranks a taken CBZ.
  always_comb begin
    w_seq     = r_pc + STEP;
    w_tgt     = r_pc + (SignExtImm64 << IMM_SHIFT);
    w_empty   = (r_cnt == '0);
    w_full    = (r_cnt == CW'(RAS_DEPTH));
    w_push    = Uncondbranch & Link & ~Ret;
    w_pop     = Ret & ~w_empty;
    w_top_inc = r_top + PW'(1);
    w_top_dec = r_top - PW'(1);
    w_next    = w_seq;
    if (Ret) begin
      if (!w_empty) w_next = r_ras[r_top];
    end else if (Uncondbranch) begin
      w_next = w_tgt;
    end else if (Branch && ALUZero) begin
      w_next = w_tgt;
    end
  end

  // PC, stack pointer, occupancy and sticky flags; everything freezes on Stall.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_pc  <= RESET_PC;
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!Stall) begin
      r_pc <= w_next;
      if (w_push) begin
        r_top <= w_top_inc;
        if (w_full) r_ovf <= 1'b1;
        else        r_cnt <= r_cnt + CW'(1);
      end else if (w_pop) begin
        r_top <= w_top_dec;
        r_cnt <= r_cnt - CW'(1);
      end else if (Ret) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Stack storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (!Stall && w_push) r_ras[w_top_inc] <= w_seq;
  end

  assign CurrentPC    = r_pc;
  assign NextPC       = w_next;
  assign RasCount     = r_cnt;
  assign RasOverflow  = r_ovf;
  assign RasUnderflow = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (default parameters).
module tb_pc_sequencer;
  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        Stall, Branch, ALUZero, Uncondbranch, Link, Ret;
  logic [63:0] SignExtImm64;
  logic [63:0] CurrentPC, NextPC;
  logic [2:0]  RasCount;
  logic        RasOverflow, RasUnderflow;

  int n_chk  = 0;
  int n_fail = 0;

  pc_sequencer dut (
    .CLK(CLK), .Reset_L(Reset_L), .Stall(Stall), .Branch(Branch),
    .ALUZero(ALUZero), .Uncondbranch(Uncondbranch), .Link(Link), .Ret(Ret),
    .SignExtImm64(SignExtImm64), .CurrentPC(CurrentPC), .NextPC(NextPC),
    .RasCount(RasCount), .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall, br, z, ub, lk, ret;
    logic [63:0] imm;
    logic [63:0] exp_next;   // NextPC before the edge
    logic [63:0] exp_pc;     // CurrentPC after the edge
    logic [2:0]  exp_cnt;
    logic        exp_ovf, exp_unf;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic st, br, z, ub, lk, ret,
                              input logic [63:0] imm, nxt, pc,
                              input logic [2:0] cnt, input logic ovf, unf);
    vec_t v;
    v.stall = st; v.br = br; v.z = z; v.ub = ub; v.lk = lk; v.ret = ret;
    v.imm = imm; v.exp_next = nxt; v.exp_pc = pc; v.exp_cnt = cnt;
    v.exp_ovf = ovf; v.exp_unf = unf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [63:0] pc,
                             input logic [2:0] cnt, input logic ovf, unf);
    check({tag, " CurrentPC"}, CurrentPC, pc);
    check({tag, " RasCount"}, 64'(RasCount), 64'(cnt));
    check({tag, " RasOverflow"}, 64'(RasOverflow), 64'(ovf));
    check({tag, " RasUnderflow"}, 64'(RasUnderflow), 64'(unf));
  endtask

  task automatic drive(input vec_t v);
    Stall = v.stall; Branch = v.br; ALUZero = v.z; Uncondbranch = v.ub;
    Link = v.lk; Ret = v.ret; SignExtImm64 = v.imm;
  endtask

  initial begin
    vec_t idle;
    //            st br z ub lk rt imm                    next             pc               cnt ovf unf
    // sequential fetch from reset
    tv.push_back(mk(0,0,0,0,0,0, 64'h0,                 64'h4,           64'h4,           0,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 64'h0,                 64'h8,           64'h8,           0,0,0));
    tv.push_back(mk(0,0,0,0,0,0, 64'h0,                 64'hC,           64'hC,           0,0,0));
    // B to 0x100
    tv.push_back(mk(0,0,0,1,0,0, 64'h3D,                64'h100,         64'h100,         0,0,0));
    // CBZ variants observed under stall (PC held at 0x100)
    tv.push_back(mk(1,1,1,0,0,0, 64'h1,                 64'h104,         64'h100,         0,0,0));
    tv.push_back(mk(1,1,0,0,0,0, 64'h1,                 64'h104,         64'h100,         0,0,0));
    tv.push_back(mk(1,1,1,0,0,0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hF8,        64'h100,         0,0,0));
    // immediate bits shifted out are discarded
    tv.push_back(mk(1,0,0,1,0,0, 64'h4000_0000_0000_0001, 64'h104,       64'h100,         0,0,0));
    // taken backward CBZ to 0x40
    tv.push_back(mk(0,1,1,0,0,0, 64'hFFFF_FFFF_FFFF_FFD0, 64'h40,        64'h40,          0,0,0));
    // BL / RET pair
    tv.push_back(mk(0,0,0,1,1,0, 64'h10,                64'h80,          64'h80,          1,0,0));
    tv.push_back(mk(0,0,0,0,0,1, 64'h0,                 64'h44,          64'h44,          0,0,0));
    // Link without Uncondbranch ignored
    tv.push_back(mk(0,0,0,0,1,0, 64'h10,                64'h48,          64'h48,          0,0,0));
    // B back to 0x0
    tv.push_back(mk(0,0,0,1,0,0, 64'hFFFF_FFFF_FFFF_FFEE, 64'h0,         64'h0,           0,0,0));
    // five nested BLs, last one overflows
    tv.push_back(mk(0,0,0,1,1,0, 64'h40,                64'h100,         64'h100,         1,0,0));
    tv.push_back(mk(0,0,0,1,1,0, 64'h40,                64'h200,         64'h200,         2,0,0));
    tv.push_back(mk(0,0,0,1,1,0, 64'h40,                64'h300,         64'h300,         3,0,0));
    tv.push_back(mk(0,0,0,1,1,0, 64'h40,                64'h400,         64'h400,         4,0,0));
    tv.push_back(mk(0,0,0,1,1,0, 64'h40,                64'h500,         64'h500,         4,1,0));
    // four RETs unwind, fifth underflows
    tv.push_back(mk(0,0,0,0,0,1, 64'h0,                 64'h404,         64'h404,         3,1,0));
    tv.push_back(mk(0,0,0,0,0,1, 64'h0,                 64'h304,         64'h304,         2,1,0));
    tv.push_back(mk(0,0,0,0,0,1, 64'h0,                 64'h204,         64'h204,         1,1,0));
    tv.push_back(mk(0,0,0,0,0,1, 64'h0,                 64'h104,         64'h104,         0,1,0));
    tv.push_back(mk(0,0,0,0,0,1, 64'h0,                 64'h108,         64'h108,         0,1,1));
    // RET on empty stack with BL asserted: no push
    tv.push_back(mk(0,0,0,1,1,1, 64'h10,                64'h10C,         64'h10C,         0,1,1));
    // stalled BL for 3 edges
    tv.push_back(mk(1,0,0,1,1,0, 64'h10,                64'h14C,         64'h10C,         0,1,1));
    tv.push_back(mk(1,0,0,1,1,0, 64'h10,                64'h14C,         64'h10C,         0,1,1));
    tv.push_back(mk(1,0,0,1,1,0, 64'h10,                64'h14C,         64'h10C,         0,1,1));
    tv.push_back(mk(0,0,0,1,1,0, 64'h10,                64'h14C,         64'h14C,         1,1,1));
    // RET wins over BL with a live entry
    tv.push_back(mk(0,0,0,1,1,1, 64'h10,                64'h110,         64'h110,         0,1,1));
    // build two entries, then Branch+Uncondbranch with ALUZero=0 acts as B
    tv.push_back(mk(0,0,0,1,1,0, 64'h4,                 64'h120,         64'h120,         1,1,1));
    tv.push_back(mk(0,0,0,1,1,0, 64'h4,                 64'h130,         64'h130,         2,1,1));
    tv.push_back(mk(0,1,0,1,0,0, 64'h4,                 64'h140,         64'h140,         2,1,1));

    idle = mk(0,0,0,0,0,0, 64'h0, 64'h0, 64'h0, 0,0,0);
    drive(idle);
    Reset_L = 1'b0;
    #1;
    check_state("reset", 64'h0, 0, 0, 0);
    check("reset NextPC", NextPC, 64'h4);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(posedge CLK); #1;
    check_state("first edge", 64'h4, 0, 0, 0);
    // re-enter from reset so the table starts at PC=0
    Reset_L = 1'b0; #1; Reset_L = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      #1;
      check($sformatf("v%0d NextPC", i), NextPC, tv[i].exp_next);
      @(posedge CLK); #1;
      check_state($sformatf("v%0d", i), tv[i].exp_pc, tv[i].exp_cnt,
                  tv[i].exp_ovf, tv[i].exp_unf);
    end

    // asynchronous reset between edges with two live RAS entries
    drive(idle);
    @(negedge CLK);
    Reset_L = 1'b0;
    #1;
    check_state("async reset", 64'h0, 0, 0, 0);
    check("async reset NextPC", NextPC, 64'h4);
    @(posedge CLK); #1;
    check_state("held in reset", 64'h0, 0, 0, 0);
    Reset_L = 1'b1;
    @(posedge CLK); #1;
    check_state("after reset", 64'h4, 0, 0, 0);
    // a RET right after reset must underflow, proving the stack was cleared
    Ret = 1'b1;
    #1;
    check("post-reset RET NextPC", NextPC, 64'h8);
    @(posedge CLK); #1;
    check_state("post-reset RET", 64'h8, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
